// File: rtl/audio_pkg.sv
// Shared types and constants for the tone sequencer: FSM states, note phase increments
// (C4..C6 at a sample rate of clk/256), datapath widths and the triangle-wave shaper.
package audio_pkg;

  localparam int unsigned SampleW  = 8;
  localparam int unsigned PhaseW   = 16;
  localparam int unsigned NoteIdxW = 4;
  localparam int unsigned RomAddrW = 6;
  localparam int unsigned TUNE_LEN = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoadAddr,
    StLoadData,
    StPlay,
    StGap
  } seq_state_e;

  // phase_inc = f * 2^16 / (25.175 MHz / 256)
  localparam logic [PhaseW-1:0] NoteRest  = 16'd0;
  localparam logic [PhaseW-1:0] NoteC4    = 16'd174;
  localparam logic [PhaseW-1:0] NoteD4    = 16'd196;
  localparam logic [PhaseW-1:0] NoteE4    = 16'd220;
  localparam logic [PhaseW-1:0] NoteF4    = 16'd233;
  localparam logic [PhaseW-1:0] NoteG4    = 16'd261;
  localparam logic [PhaseW-1:0] NoteA4    = 16'd293;
  localparam logic [PhaseW-1:0] NoteB4    = 16'd329;
  localparam logic [PhaseW-1:0] NoteC5    = 16'd349;
  localparam logic [PhaseW-1:0] NoteD5    = 16'd391;
  localparam logic [PhaseW-1:0] NoteE5    = 16'd439;
  localparam logic [PhaseW-1:0] NoteF5    = 16'd465;
  localparam logic [PhaseW-1:0] NoteG5    = 16'd522;
  localparam logic [PhaseW-1:0] NoteA5    = 16'd586;
  localparam logic [PhaseW-1:0] NoteB5    = 16'd658;
  localparam logic [PhaseW-1:0] NoteC6    = 16'd697;
  // Fast linear ramp used as the opening tone of tune 1 for an easy-to-read waveform.
  localparam logic [PhaseW-1:0] NoteSweep = 16'h0800;

  function automatic logic [SampleW-1:0] wave(input logic [PhaseW-1:0] p);
    return p[15] ? ~p[14:7] : p[14:7];
  endfunction

endpackage

// File: rtl/tune_rom.sv
// Synchronous-read 64x16 tune ROM addressed by {select, note_idx}; one cycle of latency.
// Rows for select 0 are all rests.
module tune_rom
  import audio_pkg::*;
(
  input  logic                clk,
  input  logic [RomAddrW-1:0] addr,
  output logic [PhaseW-1:0]   data
);

  localparam logic [PhaseW-1:0] Tune1 [TUNE_LEN] = '{
    NoteSweep, NoteC4, NoteE4, NoteG4, NoteC5, NoteRest, NoteG4, NoteE4,
    NoteC4, NoteD4, NoteE4, NoteF4, NoteG4, NoteA4, NoteB4, NoteC5
  };
  localparam logic [PhaseW-1:0] Tune2 [TUNE_LEN] = '{
    NoteC5, NoteE5, NoteG5, NoteC6, NoteG5, NoteE5, NoteC5, NoteRest,
    NoteD5, NoteF5, NoteA5, NoteF5, NoteD5, NoteB5, NoteG4, NoteRest
  };
  localparam logic [PhaseW-1:0] Tune3 [TUNE_LEN] = '{
    NoteA4, NoteA4, NoteE5, NoteE5, NoteF5, NoteF5, NoteE5, NoteRest,
    NoteD5, NoteD5, NoteC5, NoteC5, NoteB4, NoteB4, NoteA4, NoteRest
  };

  logic [PhaseW-1:0] rom_val;
  logic [PhaseW-1:0] data_q;

  always_comb begin
    rom_val = NoteRest;
    case (addr[5:4])
      2'd1:    rom_val = Tune1[addr[3:0]];
      2'd2:    rom_val = Tune2[addr[3:0]];
      2'd3:    rom_val = Tune3[addr[3:0]];
      default: rom_val = NoteRest;
    endcase
  end

  always_ff @(posedge clk) begin
    data_q <= rom_val;
  end

  assign data = data_q;

endmodule

// File: rtl/audio_tone_sequencer.sv
// Tune sequencer feeding the PWM stage: ROM-driven triangle tones, one sample per tick through
// a valid/ready hold register. Define AUDIO_ENVELOPE_EN for a decaying per-note envelope.
module audio_tone_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = 256,
  parameter logic [15:0] NOTE_SAMPLES = 16'd19660,
  parameter logic [15:0] GAP_SAMPLES  = 16'd1966
`ifdef AUDIO_ENVELOPE_EN
  ,
  parameter int unsigned ENV_STEP     = 64
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          audio_select,
  output logic [SampleW-1:0]  sample,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                beat,
  output logic [NoteIdxW-1:0] note_idx
);

  localparam int unsigned      DivW   = $clog2(SAMPLE_DIV);
  localparam logic [DivW-1:0]  DivMax = DivW'(SAMPLE_DIV - 1);

  logic [DivW-1:0]     div_q;
  logic                tick;
  seq_state_e          state_q, state_d;
  logic [NoteIdxW-1:0] note_idx_q, note_idx_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic [PhaseW-1:0]   phase_inc_q, phase_inc_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                beat_q, beat_d;
  logic [1:0]          sel_q;
  logic                abort_q;
  logic                abort;
  logic [PhaseW-1:0]   rom_data;
  logic [SampleW-1:0]  tick_sample;
  logic                load;
  logic [SampleW-1:0]  new_sample;
  logic [SampleW-1:0]  sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  assign tick = (div_q == DivMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
    end
  end

  // A select change is remembered until the next tick, where it restarts the tune.
  assign abort = abort_q | (audio_select != sel_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= 2'd0;
      abort_q <= 1'b0;
    end else begin
      sel_q   <= audio_select;
      abort_q <= abort & ~tick;
    end
  end

  tune_rom u_tune_rom (
    .clk  (clk),
    .addr ({audio_select, note_idx_q}),
    .data (rom_data)
  );

  always_comb begin
    state_d     = state_q;
    note_idx_d  = note_idx_q;
    phase_d     = phase_q;
    phase_inc_d = phase_inc_q;
    cnt_d       = cnt_q;
    beat_d      = 1'b0;
    tick_sample = '0;
    case (state_q)
      StIdle: begin
        note_idx_d = '0;
        phase_d    = '0;
        if (tick && (audio_select != 2'd0)) state_d = StLoadAddr;
      end
      StLoadAddr: state_d = StLoadData;
      StLoadData: begin
        phase_inc_d = rom_data;
        phase_d     = '0;
        cnt_d       = '0;
        beat_d      = 1'b1;
        state_d     = StPlay;
      end
      StPlay: begin
        if (tick) begin
          tick_sample = wave(phase_q);
          phase_d     = phase_q + phase_inc_q;
          if (cnt_q == NOTE_SAMPLES - 16'd1) begin
            cnt_d   = '0;
            state_d = StGap;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StGap: begin
        if (tick) begin
          if (cnt_q == GAP_SAMPLES - 16'd1) begin
            cnt_d      = '0;
            note_idx_d = note_idx_q + 1'b1;
            state_d    = StLoadAddr;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // LOAD never sees a tick, so the abort cannot collide with the beat above.
    if (tick && abort) begin
      note_idx_d = '0;
      cnt_d      = '0;
      state_d    = (audio_select == 2'd0) ? StIdle : StLoadAddr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      note_idx_q  <= '0;
      phase_q     <= '0;
      phase_inc_q <= '0;
      cnt_q       <= '0;
      beat_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      note_idx_q  <= note_idx_d;
      phase_q     <= phase_d;
      phase_inc_q <= phase_inc_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
    end
  end

`ifdef AUDIO_ENVELOPE_EN
  logic [7:0]         env_q, env_d;
  logic [15:0]        env_cnt_q, env_cnt_d;
  logic [SampleW-1:0] wave_q;
  logic [7:0]         env_s_q;
  logic               load_q;

  always_comb begin
    env_d     = env_q;
    env_cnt_d = env_cnt_q;
    if (state_q == StLoadData) begin
      env_d     = 8'hff;
      env_cnt_d = '0;
    end else if ((state_q == StPlay) && tick) begin
      if (env_cnt_q == 16'(ENV_STEP - 1)) begin
        env_cnt_d = '0;
        if (env_q != 8'd0) env_d = env_q - 8'd1;
      end else begin
        env_cnt_d = env_cnt_q + 16'd1;
      end
    end
  end

  // Extra stage keeps the multiplier off the tick path; env is sampled with its wave.
  always_ff @(posedge clk) begin
    if (rst) begin
      env_q     <= '0;
      env_cnt_q <= '0;
      wave_q    <= '0;
      env_s_q   <= '0;
      load_q    <= 1'b0;
    end else begin
      env_q     <= env_d;
      env_cnt_q <= env_cnt_d;
      wave_q    <= tick_sample;
      env_s_q   <= env_q;
      load_q    <= tick;
    end
  end

  assign load       = load_q;
  assign new_sample = 8'(({8'd0, wave_q} * {8'd0, env_s_q}) >> 8);
`else
  assign load       = tick;
  assign new_sample = tick_sample;
`endif

  // Newest sample always wins; dropping an unaccepted one is flagged on overrun.
  always_comb begin
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load) begin
      sample_d  = new_sample;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~sample_ready;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign beat         = beat_q;
  assign note_idx     = note_idx_q;

endmodule

// File: tb/tb_audio_tone_sequencer.sv
// Directed bench for audio_tone_sequencer with a short sample divider and short notes.
module tb_audio_tone_sequencer;

  localparam int S = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] audio_select;
  logic [7:0] sample;
  logic       sample_valid;
  logic       sample_ready;
  logic       overrun;
  logic       beat;
  logic [3:0] note_idx;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         ov_cnt = 0;
  int         acc_cnt = 0;
  int         beat_cnt = 0;
  logic [7:0] acc_last = 8'd0;

  always #5 clk = ~clk;

  audio_tone_sequencer #(
    .SAMPLE_DIV   (S),
    .NOTE_SAMPLES (16'd8),
    .GAP_SAMPLES  (16'd2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .audio_select (audio_select),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .beat         (beat),
    .note_idx     (note_idx)
  );

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    ov_cnt   <= ov_cnt + ((overrun === 1'b1) ? 1 : 0);
    beat_cnt <= beat_cnt + ((beat === 1'b1) ? 1 : 0);
    if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
      acc_cnt  <= acc_cnt + 1;
      acc_last <= sample;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output logic [7:0] val, output int n);
    val = 8'hxx;
    n   = 0;
    for (int i = 0; i < 4 * S; i++) begin
      @(negedge clk);
      n++;
      if (sample_valid === 1'b1) begin
        val = sample;
        break;
      end
    end
  endtask

  task automatic wait_beat(output int n);
    n = -1;
    for (int i = 1; i <= 12 * S; i++) begin
      @(negedge clk);
      if (beat === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int         n;
    int         t_prev;
    int         ov0;
    int         acc0;
    logic [7:0] v;

    rst          = 1'b1;
    audio_select = 2'd0;
    sample_ready = 1'b1;
    step(5);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_beat", 32'(beat), 32'd0);
    chk("rst_note_idx", 32'(note_idx), 32'd0);

    // Silence: one zero sample per divider period, no beats.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_valid(v, n);
      chk("idle_period", 32'(n), 32'(S));
      chk("idle_sample", 32'(v), 32'd0);
    end
    chk("idle_no_beat", 32'(beat_cnt), 32'd0);

    // Start tune 1: LOAD at the next tick, beat two clocks later.
    audio_select = 2'd1;
    wait_beat(n);
    chk("start_beat_delay", 32'(n), 32'(S + 2));
    chk("start_note_idx", 32'(note_idx), 32'd0);
    t_prev = cyc;
    wait_valid(v, n);
    chk("sweep_s0", 32'(v), 32'd0);
    wait_valid(v, n);
    chk("sweep_s1", 32'(v), 32'd16);

    // Stall for three ticks: loads 32, 48, 64 with two overwrites.
    step(1);
    sample_ready = 1'b0;
    ov0  = ov_cnt;
    acc0 = acc_cnt;
    step(3 * S - 1);
    chk("stall_sample", 32'(sample), 32'd64);
    chk("stall_valid", 32'(sample_valid), 32'd1);
    chk("stall_overrun_pulse", 32'(overrun), 32'd1);
    step(S - 1);
    sample_ready = 1'b1;
    step(1);
    chk("same_cycle_valid", 32'(sample_valid), 32'd1);
    chk("same_cycle_sample", 32'(sample), 32'd80);
    chk("same_cycle_no_overrun", 32'(overrun), 32'd0);
    chk("same_cycle_old_accepted", 32'(acc_last), 32'd64);
    step(1);
    chk("drain_valid", 32'(sample_valid), 32'd0);
    chk("overrun_count", 32'(ov_cnt - ov0), 32'd2);
    chk("accept_count", 32'(acc_cnt - acc0), 32'd2);
    chk("accept_last", 32'(acc_last), 32'd80);

    // Beats every 10 ticks; note index walks 1..15 then wraps to 0.
    for (int k = 1; k <= 17; k++) begin
      wait_beat(n);
      chk("beat_found", 32'(n > 0), 32'd1);
      chk("beat_interval", 32'(cyc - t_prev), 32'(10 * S));
      chk("beat_note_idx", 32'(note_idx), 32'(k % 16));
      t_prev = cyc;
      if (k == 5) begin
        wait_valid(v, n);
        chk("rest_s0", 32'(v), 32'd0);
        wait_valid(v, n);
        chk("rest_s1", 32'(v), 32'd0);
      end
    end

    // Mid-note switch to tune 2: restart at note 0 on the next tick.
    step(3 * S + 5);
    audio_select = 2'd2;
    step(S - 6);
    chk("switch_no_early_beat", 32'(beat), 32'd0);
    step(1);
    chk("switch_beat", 32'(beat), 32'd1);
    chk("switch_note_idx", 32'(note_idx), 32'd0);
    wait_valid(v, n);
    chk("tune2_s0", 32'(v), 32'd0);
    wait_valid(v, n);
    chk("tune2_s1", 32'(v), 32'd2);

    // Back to silence.
    audio_select = 2'd0;
    step(2 * S);
    chk("silence_note_idx", 32'(note_idx), 32'd0);
    wait_valid(v, n);
    chk("silence_sample", 32'(v), 32'd0);

    // Reset in the middle of the second note with a sample held.
    audio_select = 2'd1;
    wait_beat(n);
    wait_beat(n);
    sample_ready = 1'b0;
    step(S + 3);
    chk("pre_reset_valid", 32'(sample_valid), 32'd1);
    chk("pre_reset_note_idx", 32'(note_idx), 32'd1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_valid", 32'(sample_valid), 32'd0);
    chk("mid_rst_sample", 32'(sample), 32'd0);
    chk("mid_rst_note_idx", 32'(note_idx), 32'd0);
    chk("mid_rst_beat", 32'(beat), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    rst          = 1'b0;
    sample_ready = 1'b1;
    wait_beat(n);
    chk("post_rst_beat_delay", 32'(n), 32'(S + 2));
    chk("post_rst_note_idx", 32'(note_idx), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
